store_unit: RTL and testbench

STORE_UNIT -- requirements
Module: store_unit

---
 rtl/store_unit.sv | 139 +++++++++++++
 tb/tb_store_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// Store unit: turns a SB/SH/SW request into one or two lane-aligned word write beats.
// Latency: beat 0 is on mem_req the cycle after acceptance; st_done/st_err are one cycle after the final beat or a drop.
// Backpressure: st_ready is high only while idle; beat outputs hold steady until mem_gnt.
module store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [2:0]        st_funct3,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              st_done,
  output logic              st_err
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t            state, state_d;
  logic              legal;
  logic              accept;
  logic [3:0]        lane_mask;
  logic [31:0]       data_mask;
  logic [7:0]        be_wide;
  logic [63:0]       wdata_wide;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [31:0]       hi_wdata_q;
  logic [3:0]        hi_be_q;
  logic              split;
  logic              done_q;
  logic              err_q;

  // Decode size and pre-shift data/enables into an 8-lane window; the upper half is the second beat.
  always_comb begin
    legal     = 1'b0;
    lane_mask = 4'b0000;
    data_mask = 32'h0000_0000;
    case (st_funct3)
      3'd0: begin legal = 1'b1; lane_mask = 4'b0001; data_mask = 32'h0000_00ff; end
      3'd1: begin legal = 1'b1; lane_mask = 4'b0011; data_mask = 32'h0000_ffff; end
      3'd2: begin legal = 1'b1; lane_mask = 4'b1111; data_mask = 32'hffff_ffff; end
      default: begin legal = 1'b0; lane_mask = 4'b0000; data_mask = 32'h0000_0000; end
    endcase
    be_wide    = {4'b0000, lane_mask} << st_addr[1:0];
    wdata_wide = {32'h0000_0000, st_data & data_mask} << {st_addr[1:0], 3'b000};
  end

  assign accept = st_valid && st_ready;
  // Any enabled lane above the first word means the store crosses a word boundary.
  assign split  = |hi_be_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d  = state;
    st_ready = 1'b0;
    mem_req  = 1'b0;
    case (state)
      IDLE: begin
        st_ready = 1'b1;
        if (st_valid && legal) state_d = BEAT0;
      end
      BEAT0: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = split ? BEAT1 : IDLE;
      end
      BEAT1: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat registers and completion/error pulses; beat fields are zero whenever no beat is pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      hi_wdata_q <= '0;
      hi_be_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept && legal) begin
        addr_q     <= {st_addr[ADDR_W-1:2], 2'b00};
        be_q       <= be_wide[3:0];
        wdata_q    <= wdata_wide[31:0];
        hi_be_q    <= be_wide[7:4];
        hi_wdata_q <= wdata_wide[63:32];
      end else if (accept) begin
        err_q <= 1'b1;
      end
      if (state == BEAT0 && mem_gnt) begin
        if (split) begin
          addr_q  <= addr_q + ADDR_W'(4);
          be_q    <= hi_be_q;
          wdata_q <= hi_wdata_q;
        end else begin
          addr_q  <= '0;
          be_q    <= '0;
          wdata_q <= '0;
          done_q  <= 1'b1;
        end
      end
      if (state == BEAT1 && mem_gnt) begin
        addr_q     <= '0;
        be_q       <= '0;
        wdata_q    <= '0;
        hi_be_q    <= '0;
        hi_wdata_q <= '0;
        done_q     <= 1'b1;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign st_done   = done_q;
  assign st_err    = err_q;

endmodule

// File: tb/tb_store_unit.sv
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        st_done;
  logic        st_err;

  int checks = 0;
  int errors = 0;

  store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_funct3(st_funct3),
    .st_addr(st_addr), .st_data(st_data),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .st_done(st_done), .st_err(st_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd);
    chk({tag, ".req"},   64'(mem_req),   64'd1);
    chk({tag, ".addr"},  64'(mem_addr),  64'(a));
    chk({tag, ".be"},    64'(mem_be),    64'(be));
    chk({tag, ".wdata"}, 64'(mem_wdata), 64'(wd));
  endtask

  task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    st_valid  = 1'b1;
    st_funct3 = f3;
    st_addr   = a;
    st_data   = d;
  endtask

  initial begin
    rst_n    = 1'b0;
    mem_gnt  = 1'b1;
    drive_req(3'd2, 32'h0000_1000, 32'hDEAD_BEEF);

    // Reset with a request pending: nothing is accepted, everything is zero.
    @(negedge clk);
    chk("rst.req",   64'(mem_req),   64'd0);
    chk("rst.ready", 64'(st_ready),  64'd1);
    chk("rst.done",  64'(st_done),   64'd0);
    chk("rst.err",   64'(st_err),    64'd0);
    chk("rst.addr",  64'(mem_addr),  64'd0);
    chk("rst.be",    64'(mem_be),    64'd0);
    chk("rst.wdata", 64'(mem_wdata), 64'd0);
    @(negedge clk);
    chk("rst.noacc", 64'(mem_req),   64'd0);
    rst_n    = 1'b1;
    st_valid = 1'b0;
    @(negedge clk);
    chk("idle.req",  64'(mem_req),   64'd0);

    // SW aligned, zero-wait grant.
    drive_req(3'd2, 32'h0000_1000, 32'hDEAD_BEEF);
    @(negedge clk);
    chk_beat("sw", 32'h0000_1000, 4'b1111, 32'hDEAD_BEEF);
    chk("sw.ready0", 64'(st_ready), 64'd0);
    chk("sw.done0",  64'(st_done),  64'd0);
    st_valid = 1'b0;
    @(negedge clk);
    chk("sw.done",   64'(st_done),  64'd1);
    chk("sw.req_lo", 64'(mem_req),  64'd0);
    chk("sw.ready",  64'(st_ready), 64'd1);

    // SB at byte 3, presented in the st_done cycle.
    drive_req(3'd0, 32'h0000_2003, 32'hFFFF_FFA5);
    @(negedge clk);
    chk_beat("sb", 32'h0000_2000, 4'b1000, 32'hA500_0000);
    chk("sb.done0", 64'(st_done), 64'd0);
    st_valid = 1'b0;
    @(negedge clk);
    chk("sb.done",   64'(st_done), 64'd1);
    chk("sb.req_lo", 64'(mem_req), 64'd0);
    @(negedge clk);
    chk("sb.done_end", 64'(st_done), 64'd0);

    // SH crossing a word boundary.
    drive_req(3'd1, 32'h0000_3003, 32'h0000_1234);
    @(negedge clk);
    chk_beat("sh.b0", 32'h0000_3000, 4'b1000, 32'h3400_0000);
    st_valid = 1'b0;
    @(negedge clk);
    chk_beat("sh.b1", 32'h0000_3004, 4'b0001, 32'h0000_0012);
    chk("sh.done_b1", 64'(st_done), 64'd0);
    @(negedge clk);
    chk("sh.done",   64'(st_done), 64'd1);
    chk("sh.req_lo", 64'(mem_req), 64'd0);
    @(negedge clk);
    chk("sh.done_once", 64'(st_done), 64'd0);

    // SW split across the top of the address space.
    drive_req(3'd2, 32'hFFFF_FFFE, 32'h1122_3344);
    @(negedge clk);
    chk_beat("wrap.b0", 32'hFFFF_FFFC, 4'b1100, 32'h3344_0000);
    chk("wrap.err", 64'(st_err), 64'd0);
    st_valid = 1'b0;
    @(negedge clk);
    chk_beat("wrap.b1", 32'h0000_0000, 4'b0011, 32'h0000_1122);
    @(negedge clk);
    chk("wrap.done", 64'(st_done), 64'd1);
    @(negedge clk);

    // Split SH stalled in BEAT1, then abandoned by reset.
    drive_req(3'd1, 32'h0000_5003, 32'h0000_ABCD);
    @(negedge clk);
    chk_beat("stall.b0", 32'h0000_5000, 4'b1000, 32'hCD00_0000);
    st_valid = 1'b0;
    @(negedge clk);
    chk_beat("stall.b1", 32'h0000_5004, 4'b0001, 32'h0000_00AB);
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_beat($sformatf("stall.hold%0d", i), 32'h0000_5004, 4'b0001, 32'h0000_00AB);
      chk($sformatf("stall.done%0d", i), 64'(st_done), 64'd0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort.req",   64'(mem_req),  64'd0);
    chk("abort.done",  64'(st_done),  64'd0);
    chk("abort.ready", 64'(st_ready), 64'd1);
    rst_n   = 1'b1;
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("abort.done2", 64'(st_done), 64'd0);
    chk("abort.req2",  64'(mem_req), 64'd0);

    // Illegal funct3 is dropped with st_err, followed back-to-back by a SW.
    drive_req(3'd3, 32'h0000_4000, 32'h5555_5555);
    @(negedge clk);
    chk("ill.req",   64'(mem_req),  64'd0);
    chk("ill.err",   64'(st_err),   64'd1);
    chk("ill.done",  64'(st_done),  64'd0);
    chk("ill.ready", 64'(st_ready), 64'd1);
    drive_req(3'd2, 32'h0000_6000, 32'h0102_0304);
    @(negedge clk);
    chk("ill.err_end", 64'(st_err), 64'd0);
    chk_beat("b2b", 32'h0000_6000, 4'b1111, 32'h0102_0304);
    st_valid = 1'b0;
    @(negedge clk);
    chk("b2b.done", 64'(st_done), 64'd1);
    chk("b2b.err",  64'(st_err),  64'd0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
